// File: rtl/cpu_io_port.sv
// CPU word-port peripheral: a host->CPU RX FIFO and a CPU->host TX FIFO, both first-word-fall-through.
// Define CPU_IO_STATS_EN to add the rx_count/tx_count accepted-transfer counters.

module cpu_io_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  // Top bit of each pointer is the wrap bit, toggled by natural binary overflow.
  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

module cpu_io_port #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_signal,
  output logic [WIDTH-1:0] in_data,
  output logic             in_avail,
  input  logic             out_signal,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_space,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  input  logic [WIDTH-1:0] host_in_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic [WIDTH-1:0] host_out_data,
  output logic             in_underflow,
  output logic             out_overflow
`ifdef CPU_IO_STATS_EN
  ,
  output logic [31:0]      rx_count,
  output logic [31:0]      tx_count
`endif
);
  logic rx_full, rx_empty, rx_push, rx_pop;
  logic tx_full, tx_empty, tx_push, tx_pop;

  // A same-cycle CPU read frees a slot, so a full RX still takes the host word.
  assign host_in_ready = !rx_full || in_signal;
  assign rx_push       = host_in_valid && host_in_ready;
  assign rx_pop        = in_signal && !rx_empty;

  assign tx_pop  = !tx_empty && host_out_ready;
  assign tx_push = out_signal && (!tx_full || tx_pop);

  cpu_io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (host_in_data),
    .rdata (in_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  cpu_io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (out_data),
    .rdata (host_out_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign in_avail       = !rx_empty;
  assign out_space      = !tx_full;
  assign host_out_valid = !tx_empty;

  // Error flags are sticky until reset; a same-cycle host push never rescues an empty read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_underflow <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (in_signal && rx_empty)           in_underflow <= 1'b1;
      if (out_signal && tx_full && !tx_pop) out_overflow <= 1'b1;
    end
  end

`ifdef CPU_IO_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      if (rx_pop)  rx_count <= rx_count + 32'd1;
      if (tx_push) tx_count <= tx_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cpu_io_port.sv
// Directed bench for cpu_io_port at DEPTH=8, WIDTH=64; expected values are hand-derived.
module tb_cpu_io_port;
  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_signal = 1'b0;
  logic [WIDTH-1:0] in_data;
  logic             in_avail;
  logic             out_signal = 1'b0;
  logic [WIDTH-1:0] out_data = '0;
  logic             out_space;
  logic             host_in_valid = 1'b0;
  logic             host_in_ready;
  logic [WIDTH-1:0] host_in_data = '0;
  logic             host_out_valid;
  logic             host_out_ready = 1'b0;
  logic [WIDTH-1:0] host_out_data;
  logic             in_underflow;
  logic             out_overflow;
`ifdef CPU_IO_STATS_EN
  logic [31:0]      rx_count, tx_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_io_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_signal      (in_signal),
    .in_data        (in_data),
    .in_avail       (in_avail),
    .out_signal     (out_signal),
    .out_data       (out_data),
    .out_space      (out_space),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_in_data   (host_in_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_out_data  (host_out_data),
    .in_underflow   (in_underflow),
    .out_overflow   (out_overflow)
`ifdef CPU_IO_STATS_EN
    ,
    .rx_count       (rx_count),
    .tx_count       (tx_count)
`endif
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_avail"}, {63'd0, in_avail}, 64'd0);
    chk({tag, "_out_space"}, {63'd0, out_space}, 64'd1);
    chk({tag, "_host_in_ready"}, {63'd0, host_in_ready}, 64'd1);
    chk({tag, "_host_out_valid"}, {63'd0, host_out_valid}, 64'd0);
    chk({tag, "_in_data"}, in_data, 64'd0);
    chk({tag, "_host_out_data"}, host_out_data, 64'd0);
    chk({tag, "_in_underflow"}, {63'd0, in_underflow}, 64'd0);
    chk({tag, "_out_overflow"}, {63'd0, out_overflow}, 64'd0);
  endtask

  initial begin
    int sent, rcvd;
    // Reset state
    #2;
    check_idle_outputs("reset");
    step();
    reset = 1'b1;

    // RX: three host pushes, then three CPU reads
    host_in_valid = 1'b1; host_in_data = 64'h11;
    step();
    chk("rx_avail_latency", {63'd0, in_avail}, 64'd1);
    chk("rx_head_latency", in_data, 64'h11);
    host_in_data = 64'h22; step();
    host_in_data = 64'h33; step();
    host_in_valid = 1'b0;
    in_signal = 1'b1;
    #1; chk("rx_read0", in_data, 64'h11); step();
    chk("rx_read1", in_data, 64'h22); step();
    chk("rx_read2", in_data, 64'h33); step();
    in_signal = 1'b0;
    #1;
    chk("rx_avail_drained", {63'd0, in_avail}, 64'd0);
    chk("rx_no_underflow", {63'd0, in_underflow}, 64'd0);

    // RX underflow
    in_signal = 1'b1;
    #1; chk("underflow_in_data", in_data, 64'd0);
    chk("underflow_not_yet", {63'd0, in_underflow}, 64'd0);
    step();
    in_signal = 1'b0;
    chk("underflow_set", {63'd0, in_underflow}, 64'd1);
    step();
    chk("underflow_sticky", {63'd0, in_underflow}, 64'd1);

    // TX overflow: 9 writes with host stalled
    host_out_ready = 1'b0;
    out_signal = 1'b1;
    for (int i = 0; i < 9; i++) begin
      out_data = 64'h100 + 64'(i);
      if (i == 8) begin
        #1; chk("tx_space_full", {63'd0, out_space}, 64'd0);
      end
      step();
    end
    out_signal = 1'b0;
    #1;
    chk("tx_overflow_set", {63'd0, out_overflow}, 64'd1);
    chk("tx_space_after", {63'd0, out_space}, 64'd0);
    chk("tx_valid_after", {63'd0, host_out_valid}, 64'd1);
    host_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1; chk($sformatf("tx_drain%0d", i), host_out_data, 64'h100 + 64'(i));
      step();
    end
    host_out_ready = 1'b0;
    #1;
    chk("tx_drained_valid", {63'd0, host_out_valid}, 64'd0);

    // RX full with simultaneous push and pop
    host_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_in_data = 64'h200 + 64'(i);
      step();
    end
    host_in_valid = 1'b0;
    #1; chk("rx_full_ready", {63'd0, host_in_ready}, 64'd0);
    host_in_valid = 1'b1; host_in_data = 64'h208; in_signal = 1'b1;
    #1;
    chk("rx_full_ready_bypass", {63'd0, host_in_ready}, 64'd1);
    chk("rx_full_head", in_data, 64'h200);
    step();
    host_in_valid = 1'b0; in_signal = 1'b0;
    #1; chk("rx_still_full", {63'd0, host_in_ready}, 64'd0);
    in_signal = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1; chk($sformatf("rx_full_order%0d", i), in_data, 64'h201 + 64'(i));
      step();
    end
    in_signal = 1'b0;
    #1; chk("rx_full_drained", {63'd0, in_avail}, 64'd0);

    // Reset clears sticky flags
    reset = 1'b0;
    #2;
    check_idle_outputs("flag_reset");
    step();
    reset = 1'b1;
    step();

    // Stream 20 words through TX with toggling ready
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 200 && rcvd < 20; cyc++) begin
      host_out_ready = cyc[0];
      out_signal = (sent < 20) && out_space;
      out_data = 64'h300 + 64'(sent);
      #1;
      if (host_out_valid && host_out_ready) begin
        chk($sformatf("stream%0d", rcvd), host_out_data, 64'h300 + 64'(rcvd));
        rcvd++;
      end
      if (out_signal) sent++;
      step();
    end
    out_signal = 1'b0; host_out_ready = 1'b0;
    #1;
    chk("stream_count", 64'(rcvd), 64'd20);
    chk("stream_no_overflow", {63'd0, out_overflow}, 64'd0);
    chk("stream_empty", {63'd0, host_out_valid}, 64'd0);

    // Reset mid-transfer with 4 words in each FIFO
    host_in_valid = 1'b1; out_signal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_in_data = 64'h400 + 64'(i);
      out_data = 64'h500 + 64'(i);
      step();
    end
    #1;
    chk("pre_reset_in_data", in_data, 64'h400);
    chk("pre_reset_out_data", host_out_data, 64'h500);
    reset = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    host_in_valid = 1'b0; out_signal = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_reset_in_avail", {63'd0, in_avail}, 64'd0);
    chk("post_reset_out_valid", {63'd0, host_out_valid}, 64'd0);
    chk("post_reset_underflow", {63'd0, in_underflow}, 64'd0);
    chk("post_reset_overflow", {63'd0, out_overflow}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
